// File: rtl/mem_io_bridge_pkg.sv
// mem_io_bridge_pkg: shared I/O offsets, timer status bits, region and state encodings.
package mem_io_bridge_pkg;
  localparam logic [3:0] OFF_TCNT = 4'd0;
  localparam logic [3:0] OFF_TCMP = 4'd1;
  localparam logic [3:0] OFF_TSTAT = 4'd2;
  localparam logic [3:0] OFF_GPO = 4'd3;
  localparam logic [3:0] OFF_GPI = 4'd4;
  localparam int TS_FLAG = 0;
  localparam int TS_EN = 1;
  localparam int TS_IRQ = 2;
  typedef enum logic [1:0] {REG_RAM, REG_IO, REG_BAD} regionT;
  typedef enum logic {ST_IDLE, ST_ACK} stateT;
endpackage

// File: rtl/mem_io_bridge_io_timer.sv
// mem_io_bridge_io_timer: compare timer with match flag and registered interrupt.
module mem_io_bridge_io_timer
  import mem_io_bridge_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        we,
  input  logic [3:0]  off,
  input  logic [15:0] wdata,
  output logic [15:0] tcnt,
  output logic [15:0] tcmp,
  output logic [2:0]  tstat,
  output logic        timer_irq
);
  logic match, clrFlag;
  always_comb begin
    match = tstat[TS_EN] && tcnt == tcmp;
    clrFlag = we && off == OFF_TSTAT && wdata[TS_FLAG];
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tcnt <= '0;
      tcmp <= 16'hFFFF;
      tstat <= '0;
      timer_irq <= 1'b0;
    end else begin
      tcnt <= (we && off == OFF_TCNT) ? wdata : match ? '0 : tstat[TS_EN] ? tcnt + 16'd1 : tcnt;
      if (we && off == OFF_TCMP) tcmp <= wdata;
      tstat[TS_FLAG] <= match | (tstat[TS_FLAG] & ~clrFlag);
      if (we && off == OFF_TSTAT) begin
        tstat[TS_EN] <= wdata[TS_EN];
        tstat[TS_IRQ] <= wdata[TS_IRQ];
      end
      timer_irq <= tstat[TS_FLAG] & tstat[TS_IRQ];
    end
  end
endmodule

// File: rtl/mem_io_bridge.sv
// mem_io_bridge: CPU load/store front end decoding RAM, I/O and unmapped regions with a req/ack handshake.
module mem_io_bridge
  import mem_io_bridge_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int RAM_ADDR_BITS = 15,
  parameter logic [15:0] IO_BASE = 16'hFFF0
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     cpu_req,
  input  logic                     cpu_we,
  input  logic [15:0]              cpu_addr,
  input  logic [DATA_WIDTH-1:0]    cpu_wdata,
  output logic [DATA_WIDTH-1:0]    cpu_rdata,
  output logic                     cpu_ack,
  output logic                     cpu_busy,
  output logic                     cpu_err,
  output logic                     mem_en,
  output logic                     mem_we,
  output logic [RAM_ADDR_BITS-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_din,
  input  logic [DATA_WIDTH-1:0]    mem_dout,
  input  logic [15:0]              gpio_in,
  output logic [15:0]              gpio_out,
  output logic                     timer_irq
);
  stateT state, nextState;
  regionT region, regionQ;
  logic accept, ioWe, weQ;
  logic [3:0] off;
  logic [15:0] ioRd, tcnt, tcmp, gpiMeta, gpiSync;
  logic [2:0] tstat;
  logic [DATA_WIDTH-1:0] rdataQ;
  always_comb begin
    region = (cpu_addr >> RAM_ADDR_BITS) == 16'd0 ? REG_RAM : cpu_addr >= IO_BASE ? REG_IO : REG_BAD;
    accept = state == ST_IDLE && cpu_req;
    nextState = accept ? ST_ACK : ST_IDLE;
    off = cpu_addr[3:0];
    ioWe = accept && cpu_we && region == REG_IO;
    ioRd = off == OFF_TCNT ? tcnt : off == OFF_TCMP ? tcmp : off == OFF_TSTAT ? {13'd0, tstat} :
           off == OFF_GPO ? gpio_out : off == OFF_GPI ? gpiSync : 16'd0;
    mem_en = accept && region == REG_RAM;
    mem_we = mem_en && cpu_we;
    mem_addr = cpu_addr[RAM_ADDR_BITS-1:0];
    mem_din = cpu_wdata;
    cpu_busy = state == ST_ACK;
    cpu_ack = cpu_busy;
    cpu_err = cpu_busy && regionQ == REG_BAD;
    // RAM loads pass the BRAM output straight through; everything else was captured at accept
    cpu_rdata = !cpu_busy ? '0 : (regionQ == REG_RAM && !weQ) ? mem_dout : rdataQ;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else state <= nextState;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      regionQ <= REG_RAM;
      weQ <= 1'b0;
      rdataQ <= '0;
      gpio_out <= '0;
      gpiMeta <= '0;
      gpiSync <= '0;
    end else begin
      gpiMeta <= gpio_in;
      gpiSync <= gpiMeta;
      if (ioWe && off == OFF_GPO) gpio_out <= 16'(cpu_wdata);
      if (accept) begin
        regionQ <= region;
        weQ <= cpu_we;
        rdataQ <= region == REG_BAD ? '0 : cpu_we ? cpu_wdata : DATA_WIDTH'(ioRd);
      end
    end
  end
  mem_io_bridge_io_timer u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .we       (ioWe),
    .off      (off),
    .wdata    (16'(cpu_wdata)),
    .tcnt     (tcnt),
    .tcmp     (tcmp),
    .tstat    (tstat),
    .timer_irq(timer_irq)
  );
endmodule

// File: tb/tb_mem_io_bridge.sv
// tb_mem_io_bridge: directed checks of RAM, I/O, unmapped, timer, GPIO and reset behaviour.
module tb_mem_io_bridge;
  logic clk = 1'b0;
  logic reset_n;
  logic cpu_req, cpu_we;
  logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic cpu_ack, cpu_busy, cpu_err, mem_en, mem_we;
  logic [14:0] mem_addr;
  logic [15:0] mem_din, mem_dout, gpio_in, gpio_out;
  logic timer_irq;
  logic [15:0] ram [32768];
  int checks = 0;
  int failures = 0;
  mem_io_bridge dut (
    .clk(clk), .reset_n(reset_n), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_busy(cpu_busy),
    .cpu_err(cpu_err), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout), .gpio_in(gpio_in), .gpio_out(gpio_out), .timer_irq(timer_irq)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_din;
      mem_dout <= ram[mem_addr];
    end
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic doAcc(input string tag, input logic we, input logic [15:0] addr, input logic [15:0] wd,
                       input logic [15:0] expRd, input logic chkRd, input logic expErr, input logic expEn);
    cpu_req = 1'b1;
    cpu_we = we;
    cpu_addr = addr;
    cpu_wdata = wd;
    #1;
    check({tag, ".en"}, 32'(mem_en), 32'(expEn));
    check({tag, ".we"}, 32'(mem_we), 32'(we & expEn));
    if (expEn) check({tag, ".addr"}, 32'(mem_addr), 32'(addr[14:0]));
    tick();
    cpu_req = 1'b0;
    cpu_we = 1'b0;
    #1;
    check({tag, ".ack"}, 32'(cpu_ack), 32'd1);
    check({tag, ".err"}, 32'(cpu_err), 32'(expErr));
    if (chkRd) check({tag, ".rd"}, 32'(cpu_rdata), 32'(expRd));
    tick();
    check({tag, ".ackend"}, 32'(cpu_ack), 32'd0);
  endtask
  initial begin
    for (int i = 0; i < 32768; i++) ram[i] = 16'h0000;
    mem_dout = 16'h0000;
    reset_n = 1'b0;
    cpu_req = 1'b0;
    cpu_we = 1'b0;
    cpu_addr = 16'h0000;
    cpu_wdata = 16'h0000;
    gpio_in = 16'h0000;
    tick();
    tick();
    check("rst.ack", 32'(cpu_ack), 32'd0);
    check("rst.err", 32'(cpu_err), 32'd0);
    check("rst.rdata", 32'(cpu_rdata), 32'd0);
    check("rst.gpo", 32'(gpio_out), 32'd0);
    check("rst.irq", 32'(timer_irq), 32'd0);
    check("rst.busy", 32'(cpu_busy), 32'd0);
    reset_n = 1'b1;
    tick();
    doAcc("st0123", 1'b1, 16'h0123, 16'hBEEF, 16'hBEEF, 1'b1, 1'b0, 1'b1);
    check("ram0123", 32'(ram[15'h0123]), 32'h0000BEEF);
    doAcc("ld0123", 1'b0, 16'h0123, 16'h0000, 16'hBEEF, 1'b1, 1'b0, 1'b1);
    cpu_req = 1'b1;
    cpu_we = 1'b0;
    cpu_addr = 16'h0123;
    tick();
    #1;
    check("busy.busy", 32'(cpu_busy), 32'd1);
    check("busy.en", 32'(mem_en), 32'd0);
    check("busy.rd", 32'(cpu_rdata), 32'h0000BEEF);
    tick();
    cpu_req = 1'b0;
    #1;
    check("busy.noack", 32'(cpu_ack), 32'd0);
    doAcc("represent", 1'b0, 16'h0123, 16'h0000, 16'hBEEF, 1'b1, 1'b0, 1'b1);
    doAcc("ld9000", 1'b0, 16'h9000, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0);
    doAcc("st8000", 1'b1, 16'h8000, 16'h7777, 16'h0000, 1'b1, 1'b1, 1'b0);
    doAcc("ld0000", 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1);
    doAcc("stFFF7", 1'b1, 16'hFFF7, 16'h4321, 16'h0000, 1'b0, 1'b0, 1'b0);
    doAcc("ldFFF7", 1'b0, 16'hFFF7, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0);
    #3 gpio_in = 16'h00A5;
    tick();
    tick();
    doAcc("ldGPI", 1'b0, 16'hFFF4, 16'h0000, 16'h00A5, 1'b1, 1'b0, 1'b0);
    doAcc("stGPO", 1'b1, 16'hFFF3, 16'h1234, 16'h0000, 1'b0, 1'b0, 1'b0);
    check("gpo", 32'(gpio_out), 32'h00001234);
    doAcc("ldGPO", 1'b0, 16'hFFF3, 16'h0000, 16'h1234, 1'b1, 1'b0, 1'b0);
    doAcc("stTCMP", 1'b1, 16'hFFF1, 16'h0003, 16'h0000, 1'b0, 1'b0, 1'b0);
    doAcc("stTSTAT", 1'b1, 16'hFFF2, 16'h0006, 16'h0000, 1'b0, 1'b0, 1'b0);
    check("tcnt1", 32'(dut.u_timer.tcnt), 32'd1);
    tick();
    check("tcnt2", 32'(dut.u_timer.tcnt), 32'd2);
    tick();
    check("tcnt3", 32'(dut.u_timer.tcnt), 32'd3);
    check("irq.pre", 32'(timer_irq), 32'd0);
    tick();
    check("tcnt.wrap", 32'(dut.u_timer.tcnt), 32'd0);
    check("flag.set", 32'(dut.u_timer.tstat[0]), 32'd1);
    check("irq.lag", 32'(timer_irq), 32'd0);
    tick();
    check("irq.set", 32'(timer_irq), 32'd1);
    doAcc("clr", 1'b1, 16'hFFF2, 16'h0007, 16'h0000, 1'b0, 1'b0, 1'b0);
    check("clr.flag", 32'(dut.u_timer.tstat[0]), 32'd0);
    check("clr.irq", 32'(timer_irq), 32'd0);
    check("clr.tcnt", 32'(dut.u_timer.tcnt), 32'd3);
    doAcc("clrmatch", 1'b1, 16'hFFF2, 16'h0007, 16'h0000, 1'b0, 1'b0, 1'b0);
    check("cm.flag", 32'(dut.u_timer.tstat[0]), 32'd1);
    check("cm.irq", 32'(timer_irq), 32'd1);
    doAcc("ldTSTAT", 1'b0, 16'hFFF2, 16'h0000, 16'h0007, 1'b1, 1'b0, 1'b0);
    doAcc("st0200", 1'b1, 16'h0200, 16'hCAFE, 16'hCAFE, 1'b1, 1'b0, 1'b1);
    cpu_req = 1'b1;
    cpu_we = 1'b0;
    cpu_addr = 16'h0123;
    tick();
    cpu_req = 1'b0;
    check("rstmid.ack", 32'(cpu_ack), 32'd1);
    reset_n = 1'b0;
    #1;
    check("rstmid.noack", 32'(cpu_ack), 32'd0);
    check("rstmid.busy", 32'(cpu_busy), 32'd0);
    check("rstmid.gpo", 32'(gpio_out), 32'd0);
    check("rstmid.irq", 32'(timer_irq), 32'd0);
    #2 reset_n = 1'b1;
    tick();
    check("post.noack", 32'(cpu_ack), 32'd0);
    doAcc("ld0200", 1'b0, 16'h0200, 16'h0000, 16'hCAFE, 1'b1, 1'b0, 1'b1);
    doAcc("ldTCMP", 1'b0, 16'hFFF1, 16'h0000, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    doAcc("ldTCNT", 1'b0, 16'hFFF0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0);
    doAcc("ldGPOr", 1'b0, 16'hFFF3, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_io_bridge.md
Name: mem_io_bridge

Overview:
- Load/store front end between CPU datapath and port A of the dual-port block RAM; port B is left for the instruction fetch path.
- Decodes each CPU access to one of three regions: RAM (0x0000-0x7FFF), memory-mapped I/O (0xFFF0-0xFFFF), or unmapped (all else).
- Hides the 1-cycle synchronous BRAM read latency behind a req/ack handshake.
- Hosts a compare timer, motor GPIO output and synchronised switch input for the motor board.

Parameters:
- DATA_WIDTH, 16, CPU word and RAM word width.
- RAM_ADDR_BITS, 15, RAM word-address width; RAM occupies CPU addresses 0 to 2**RAM_ADDR_BITS-1.
- IO_BASE, 16'hFFF0, base of the 16-word I/O window.

Ports:
- clk  in  1  single system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cpu_req  in  1  access request; sampled only in IDLE.
- cpu_we  in  1  1 = store, 0 = load.
- cpu_addr  in  16  CPU word address.
- cpu_wdata  in  DATA_WIDTH  store data.
- cpu_rdata  out  DATA_WIDTH  load data; valid when cpu_ack = 1.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_busy  out  1  high when a request would be ignored.
- cpu_err  out  1  with cpu_ack: access hit the unmapped region.
- mem_en  out  1  RAM port A enable.
- mem_we  out  1  RAM port A write enable.
- mem_addr  out  RAM_ADDR_BITS  RAM port A address.
- mem_din  out  DATA_WIDTH  RAM port A write data.
- mem_dout  in  DATA_WIDTH  RAM port A read data; valid 1 cycle after mem_en.
- gpio_in  in  16  asynchronous switch inputs.
- gpio_out  out  16  motor drive register.
- timer_irq  out  1  timer interrupt, level.

Behaviour:
Reset (asynchronous, reset_n = 0):
- Outputs: state = IDLE; cpu_ack, cpu_err, cpu_rdata, gpio_out, timer_irq all 0.
- Timer registers: TCNT = 0, TCMP = 16'hFFFF, TSTAT = 0.
- gpio_in synchroniser flops = 0.

State machine: IDLE -> ACK -> IDLE.
- IDLE, cpu_req = 1: accept the request, latch region and address, go to ACK.
- ACK: cpu_ack = 1 for exactly one cycle, then IDLE.
- cpu_busy = (state == ACK).
- A request presented while in ACK is ignored; the CPU must re-present it.
- Throughput: one access per 2 cycles. Latency: ack on the cycle after the request.

RAM region (cpu_addr[15] = 0):
- mem_en, mem_we and mem_addr are driven combinationally during the accept cycle only: mem_en = 1, mem_we = cpu_we, mem_addr = cpu_addr[14:0], mem_din = cpu_wdata.
- At all other times mem_en = 0 and mem_we = 0.
- Load: in ACK, cpu_rdata = mem_dout.
- Store: in ACK, cpu_rdata = cpu_wdata (write-first echo).

I/O region (cpu_addr >= IO_BASE). Word offsets:
- 0 TCNT, read/write.
- 1 TCMP, read/write.
- 2 TSTAT, status/control:
  - bit0 match flag; write 1 clears it.
  - bit1 count enable.
  - bit2 irq enable.
  - Reads return bits [2:0], zeros above.
- 3 GPIO_OUT, read/write.
- 4 GPIO_IN, read-only; 2-flop synchronised.
- 5 to 15: read 0, writes ignored, no error.
- I/O writes commit at the end of the accept cycle. I/O read data is registered into cpu_rdata for ACK.

Unmapped region (0x8000 up to IO_BASE-1):
- In ACK: cpu_ack = 1, cpu_err = 1, cpu_rdata = 0.
- No RAM enable and no register change.

Timer:
- Per cycle when bit1 = 1: if TCNT == TCMP, then TCNT <= 0 and flag <= 1; else TCNT <= TCNT + 1 (wraps modulo 2**16).
- CPU write to TCNT in the same cycle as an increment: the write wins.
- Match and write-1-clear in the same cycle: the set wins, flag stays 1.
- timer_irq = flag & bit2, registered.

Reset mid-operation:
- A RAM store already issued in the accept cycle stays committed.
- No ack is produced.
- All state returns to IDLE.

Decomposition:
- Shared package holds:
  - I/O offset constants: OFF_TCNT = 0, OFF_TCMP = 1, OFF_TSTAT = 2, OFF_GPO = 3, OFF_GPI = 4.
  - TSTAT bit indices.
  - Region encoding: REG_RAM, REG_IO, REG_BAD.
  - State encoding: ST_IDLE, ST_ACK.
- One sub-module, io_timer: TCNT/TCMP/TSTAT, match logic and irq.
- GPIO registers and the synchroniser stay in the top level.

Test Plan:
- Store 0xBEEF to 0x0123, then load 0x0123:
  - mem_en = 1 and mem_we = 1 only in the store's accept cycle, mem_addr = 0x0123.
  - Load acks 1 cycle after request with cpu_rdata = 0xBEEF, cpu_err = 0.
- Request in the ACK cycle: cpu_busy = 1 and the request is ignored (no mem_en, no second ack); the same request re-presented in IDLE is served.
- Load 0x9000: ack with cpu_err = 1, cpu_rdata = 0, mem_en never asserted. Store 0x8000: same response, RAM unchanged.
- Timer count and match:
  - Stimulus: write TCMP = 3, TSTAT = 0b110.
  - TCNT counts 0,1,2,3, then 0; flag sets and timer_irq = 1 one cycle later.
  - Write TSTAT = 0b111 in a non-match cycle: flag clears and timer_irq drops.
  - Write 1-clear coinciding with a match: flag stays 1.
- gpio_in = 0x00A5 applied asynchronously: load 0xFFF4 returns 0x00A5 once the 2-flop synchroniser has settled. Store 0x1234 to 0xFFF3: gpio_out = 0x1234 from the next cycle.
- reset_n pulsed low during ACK of a load: cpu_ack deasserts immediately and gpio_out = 0, TCMP = 0xFFFF, state IDLE. A store issued just before reset is visible on a later load.
